// File: rtl/hex_display_scanner.sv
// Multiplexed hex display driver: one shared active-low abcdefg segment bus,
// per-digit active-low enables, blanking gap per slot, frame-aligned word updates.

module hex7seg (
    input  logic [3:0] digit,
    output logic [1:7] seg_c
);
    // Active-low abcdefg pattern for each hex digit
    always_comb begin
        case (digit)
            4'h0:    seg_c = 7'b0000001;
            4'h1:    seg_c = 7'b1001111;
            4'h2:    seg_c = 7'b0010010;
            4'h3:    seg_c = 7'b0000110;
            4'h4:    seg_c = 7'b1001100;
            4'h5:    seg_c = 7'b0100100;
            4'h6:    seg_c = 7'b0100000;
            4'h7:    seg_c = 7'b0001111;
            4'h8:    seg_c = 7'b0000000;
            4'h9:    seg_c = 7'b0000100;
            4'hA:    seg_c = 7'b0001000;
            4'hB:    seg_c = 7'b1100000;
            4'hC:    seg_c = 7'b0110001;
            4'hD:    seg_c = 7'b1000010;
            4'hE:    seg_c = 7'b0110000;
            default: seg_c = 7'b0111000;
        endcase
    end
endmodule

module hex_display_scanner #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 1000,
    parameter int unsigned BLANK      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [1:7]                leds,
    output logic                      pending,
    output logic                      frame_done
);
    localparam int unsigned TW = $clog2(DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned DW = 4 * NUM_DIGITS;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          tick, tick_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DW-1:0]          staged, shadow, shadow_n;
    logic [NUM_DIGITS-1:0]  staged_mask, shadow_mask, shadow_mask_n;
    logic                   slot_end, frame_end;
    logic [3:0]             digit;
    logic [1:7]             seg;
    logic [NUM_DIGITS-1:0]  an_n;
    logic [1:7]             leds_n;

    hex7seg u_dec (
        .digit (digit),
        .seg_c (seg)
    );

    // Next-state of the scan; outputs are registered from these values so the
    // first SHOW cycle of a slot already drives the digit.
    always_comb begin
        slot_end      = (tick == TW'(DIV - 1));
        frame_end     = slot_end && (idx == IW'(NUM_DIGITS - 1));
        tick_n        = slot_end ? '0 : tick + TW'(1);
        idx_n         = idx;
        shadow_n      = shadow;
        shadow_mask_n = shadow_mask;
        state_n       = state;
        an_n          = '1;
        leds_n        = '1;

        if (slot_end) begin
            idx_n = frame_end ? '0 : idx + IW'(1);
        end
        if (frame_end) begin
            shadow_n      = staged;
            shadow_mask_n = staged_mask;
        end

        if (slot_end) begin
            state_n = ST_BLANK;
        end else if (state == ST_BLANK && tick_n == TW'(BLANK)) begin
            state_n = ST_SHOW;
        end

        digit = shadow_n[{idx_n, 2'b00} +: 4];
        if (state_n == ST_SHOW && !shadow_mask_n[idx_n]) begin
            an_n[idx_n] = 1'b0;
            leds_n      = seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick        <= '0;
            idx         <= '0;
            state       <= ST_BLANK;
            staged      <= '0;
            staged_mask <= '0;
            shadow      <= '0;
            shadow_mask <= '0;
            pending     <= 1'b0;
            frame_done  <= 1'b0;
            an          <= '1;
            leds        <= '1;
        end else begin
            tick        <= tick_n;
            idx         <= idx_n;
            state       <= state_n;
            shadow      <= shadow_n;
            shadow_mask <= shadow_mask_n;
            frame_done  <= frame_end;
            an          <= an_n;
            leds        <= leds_n;
            // A load on the boundary edge stays staged and keeps pending set
            if (load) begin
                staged      <= value;
                staged_mask <= blank_mask;
                pending     <= 1'b1;
            end else if (frame_end) begin
                pending     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner: directed scenarios plus random
// loads, compared each cycle against a frame/slot arithmetic model.

module tb_hex_display_scanner;
    localparam int NUM_DIGITS = 4;
    localparam int DIV        = 8;
    localparam int BLANK      = 2;
    localparam int FRAME      = NUM_DIGITS * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  an;
    logic [1:7]  leds;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int c = 0;

    int          ld_cyc[$];
    logic [15:0] ld_val[$];
    logic [3:0]  ld_msk[$];

    hex_display_scanner #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIV        (DIV),
        .BLANK      (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .an         (an),
        .leds       (leds),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Word shown in frame f: last load captured strictly before that frame's boundary edge
    task automatic word_for_frame(input int f, output logic [15:0] w, output logic [3:0] m);
        w = '0;
        m = '0;
        if (f > 0) begin
            for (int k = 0; k < ld_cyc.size(); k++) begin
                if (ld_cyc[k] <= FRAME * f - 2) begin
                    w = ld_val[k];
                    m = ld_msk[k];
                end
            end
        end
    endtask

    function automatic logic exp_pending(input int cyc);
        int last;
        if (ld_cyc.size() == 0) return 1'b0;
        last = ld_cyc[ld_cyc.size() - 1];
        if (cyc < FRAME) return 1'b1;
        return (last >= FRAME * (cyc / FRAME) - 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, got, exp);
        end
    endtask

    task automatic check_cycle();
        int t, i, f;
        logic [15:0] w;
        logic [3:0]  m;
        logic [3:0]  ea;
        logic [6:0]  el;
        t = c % DIV;
        i = (c / DIV) % NUM_DIGITS;
        f = c / FRAME;
        word_for_frame(f, w, m);
        ea = '1;
        el = '1;
        if (t >= BLANK && !m[i]) begin
            ea[i] = 1'b0;
            el    = seg(w[4*i +: 4]);
        end
        chk("an", 7'(an), 7'(ea));
        chk("leds", leds, el);
        chk("pending", 7'(pending), 7'(exp_pending(c)));
        chk("frame_done", 7'(frame_done), 7'((c >= FRAME && c % FRAME == 0) ? 1 : 0));
    endtask

    task automatic run_cycle(input logic do_load, input logic [15:0] v, input logic [3:0] m);
        check_cycle();
        if (do_load) begin
            load       = 1'b1;
            value      = v;
            blank_mask = m;
            ld_cyc.push_back(c);
            ld_val.push_back(v);
            ld_msk.push_back(m);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        c++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ld_cyc.delete();
        ld_val.delete();
        ld_msk.delete();
        c = 0;
    endtask

    initial begin
        // Reset held for three edges
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_an", 7'(an), 7'(4'b1111));
            chk("rst_leds", leds, 7'b1111111);
            chk("rst_pending", 7'(pending), 7'd0);
            chk("rst_frame_done", 7'(frame_done), 7'd0);
        end
        reset = 1'b0;
        c = 0;

        // Directed: load, boundary-edge load, masked digit
        while (c <= 130) begin
            if (c == 2) begin
                chk("first_show_an", 7'(an), 7'(4'b1110));
                chk("first_show_leds", leds, 7'b0000001);
            end
            if (c == 34) chk("frame1_d0_4", leds, 7'b1001100);
            if (c == 40) chk("boundary_load_pending", 7'(pending), 7'd1);
            if (c == 58) chk("frame1_d3_1", leds, 7'b1001111);
            if (c == 64) chk("pending_cleared", 7'(pending), 7'd0);
            if (c == 66) chk("frame2_d0_D", leds, 7'b1000010);
            if (c == 96 + 2 * DIV + 3) chk("masked_d2_an", 7'(an), 7'(4'b1111));
            if (c == 5)       run_cycle(1'b1, 16'h1234, 4'b0000);
            else if (c == 31) run_cycle(1'b1, 16'hABCD, 4'b0000);
            else if (c == 70) run_cycle(1'b1, 16'h1234, 4'b0100);
            else              run_cycle(1'b0, '0, '0);
        end

        // Random loads, occasionally masked
        for (int k = 0; k < 420; k++) begin
            if ($urandom_range(0, 5) == 0)
                run_cycle(1'b1, 16'($urandom),
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
            else
                run_cycle(1'b0, '0, '0);
        end

        // Reset during a SHOW cycle of digit 1 with a word pending
        for (int k = 0; k < 2 * FRAME && (c % FRAME) != 5; k++) run_cycle(1'b0, '0, '0);
        run_cycle(1'b1, 16'($urandom) | 16'h0001, 4'b0000);
        for (int k = 0; k < 2 * FRAME && (c % FRAME) != DIV + 5; k++) run_cycle(1'b0, '0, '0);
        chk("pre_reset_pending", 7'(pending), 7'd1);
        chk("pre_reset_an", 7'(an), 7'(4'b1101));
        do_reset();
        chk("mid_reset_an", 7'(an), 7'(4'b1111));
        chk("mid_reset_leds", leds, 7'b1111111);
        chk("mid_reset_pending", 7'(pending), 7'd0);
        while (c < 70) begin
            if (c == DIV + 3) begin
                chk("restart_an", 7'(an), 7'(4'b1101));
                chk("restart_leds", leds, 7'b0000001);
            end
            run_cycle(1'b0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
